cpu_reset_sequencer: RTL and testbench

CPU_RESET_SEQUENCER -- requirements
Module: cpu_reset_sequencer

---
 rtl/cpu_reset_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_reset_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu_reset_sequencer.sv
// Software-requested reset sequencer for a Nios II core: request, acknowledge, hold, re-arm.
// Optional macro CPURST_TIMEOUT_EN forces HOLD if the CPU never acknowledges within TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | waiting for a rising edge of the synchronized software request
// REQ   | cpu_resetrequest asserted, waiting for cpu_resettaken (or timeout)
// HOLD  | cpu_resetrequest held for HOLD_CYCLES cycles
// REARM | request released, waiting for the software request to drop
module cpu_reset_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clock_sig,
    input  logic       reset_n,
    input  logic       swi_reset_req,
    input  logic       cpu_resettaken,
    output logic       cpu_resetrequest,
    output logic       busy,
    output logic       timeout_flag,
    output logic [7:0] reset_count
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("cpu_reset_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        REARM = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic       sync_1;
    logic       req_s;
    logic       req_prev;
    logic [1:0] fill_cnt;
    logic       armed;
    logic [7:0] hold_cnt;
    logic       trigger;

`ifdef CPURST_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    // A request already high at reset release must be seen low once before it can trigger.
    assign trigger = req_s & ~req_prev & armed;

    always_ff @(posedge clock_sig or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            sync_1           <= 1'b0;
            req_s            <= 1'b0;
            req_prev         <= 1'b0;
            fill_cnt         <= 2'd0;
            armed            <= 1'b0;
            hold_cnt         <= 8'd0;
            cpu_resetrequest <= 1'b0;
            busy             <= 1'b0;
            reset_count      <= 8'd0;
`ifdef CPURST_TIMEOUT_EN
            wait_cnt         <= 16'd0;
            timeout_flag     <= 1'b0;
`endif
        end else begin
            sync_1   <= swi_reset_req;
            req_s    <= sync_1;
            req_prev <= req_s;
            if (fill_cnt != 2'd2) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            if (fill_cnt == 2'd2 && !req_s) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state            <= REQ;
                        cpu_resetrequest <= 1'b1;
                        busy             <= 1'b1;
`ifdef CPURST_TIMEOUT_EN
                        wait_cnt         <= 16'd0;
`endif
                    end
                end
                REQ: begin
                    if (cpu_resettaken) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
`ifdef CPURST_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        state        <= HOLD;
                        hold_cnt     <= HOLD_LOAD;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state            <= REARM;
                        cpu_resetrequest <= 1'b0;
                        reset_count      <= reset_count + 8'd1;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                REARM: begin
                    if (!req_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Bench for cpu_reset_sequencer: directed and random request/acknowledge patterns against an event-time model.
// Works with or without CPURST_TIMEOUT_EN defined.
module tb_cpu_reset_sequencer;

    localparam int H = 16;
    localparam int T = 1024;

    logic       clock_core_sig = 1'b0;
    logic       qsys_reset_n_sig = 1'b0;
    logic       swi_reset_req = 1'b0;
    logic       cpu_resettaken = 1'b0;
    logic       cpu_resetrequest;
    logic       busy;
    logic       timeout_flag;
    logic [7:0] reset_count;

    int n_cmp = 0;
    int n_bad = 0;
    int m_seq = 0;
    logic m_flag = 1'b0;

    cpu_reset_sequencer #(.HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
        .clock_sig        (clock_core_sig),
        .reset_n          (qsys_reset_n_sig),
        .swi_reset_req    (swi_reset_req),
        .cpu_resettaken   (cpu_resettaken),
        .cpu_resetrequest (cpu_resetrequest),
        .busy             (busy),
        .timeout_flag     (timeout_flag),
        .reset_count      (reset_count)
    );

    always #5 clock_core_sig = ~clock_core_sig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_core_sig);
        #1;
    endtask

    // Software request waveform: first pulse from 0 for p cycles, optional second pulse at g2 for l2 cycles.
    function automatic logic swi_at(input int i, input int p, input int g2, input int l2);
        return (i >= 0 && i < p) || (l2 > 0 && i >= g2 && i < g2 + l2);
    endfunction

    // Expected event edges (edge k = k-th rising edge after the request starts):
    // request seen 3 edges after it rises; HOLD entry on the ack edge (or timeout edge);
    // release H edges later; IDLE on the first later edge whose synchronized request is low.
    task automatic run_seq(input string tag, input int p, input int a, input int g2, input int l2);
        int  hold_e, fall_e, idle_e, n;
        int  rise, fall, idle, brise, rises;
        bit  timed, prev_rr, prev_busy;
        timed = 0;
`ifdef CPURST_TIMEOUT_EN
        if (a - 2 <= T) hold_e = a + 1;
        else begin
            hold_e = 3 + T;
            timed  = 1;
        end
`else
        hold_e = a + 1;
`endif
        fall_e = hold_e + H;
        idle_e = fall_e + 1;
        while (swi_at(idle_e - 3, p, g2, l2)) idle_e++;
        n = idle_e + 4;
        rise = -1; fall = -1; idle = -1; brise = -1; rises = 0;
        prev_rr = 0; prev_busy = 0;
        for (int i = 0; i < n; i++) begin
            swi_reset_req  = swi_at(i, p, g2, l2);
            cpu_resettaken = (i == a) || (i == 1) || (i == fall_e);
            step();
            if (cpu_resetrequest && !prev_rr) begin
                rises++;
                if (rise < 0) rise = i + 1;
            end
            if (!cpu_resetrequest && prev_rr && fall < 0) fall = i + 1;
            if (busy && !prev_busy && brise < 0) brise = i + 1;
            if (!busy && prev_busy && idle < 0) idle = i + 1;
            prev_rr   = cpu_resetrequest;
            prev_busy = busy;
        end
        swi_reset_req  = 1'b0;
        cpu_resettaken = 1'b0;
        m_seq++;
        if (timed) m_flag = 1'b1;
        chk({tag, " req_rise_edge"}, rise, 3);
        chk({tag, " req_pulses"}, rises, 1);
        chk({tag, " req_fall_edge"}, fall, fall_e);
        chk({tag, " busy_rise_edge"}, brise, 3);
        chk({tag, " busy_fall_edge"}, idle, idle_e);
        chk({tag, " reset_count"}, reset_count, m_seq % 256);
        chk({tag, " timeout_flag"}, timeout_flag, m_flag);
    endtask

    initial begin
        int seen;
        qsys_reset_n_sig = 1'b0;
        repeat (3) step();
        chk("rst resetrequest", cpu_resetrequest, 0);
        chk("rst busy", busy, 0);
        chk("rst reset_count", reset_count, 0);
        chk("rst timeout_flag", timeout_flag, 0);
        qsys_reset_n_sig = 1'b1;
        repeat (4) step();

        run_seq("pulse5_ack10", 5, 12, 0, 0);
        run_seq("held200", 200, 3, 0, 0);
        run_seq("retrig_in_hold", 5, 6, 12, 3);
        run_seq("after_retrig", 3, 4, 0, 0);
        run_seq("ack_on_timeout_edge", 2, T + 2, 0, 0);
        run_seq("no_ack", 2, 1500, 0, 0);
        for (int k = 0; k < 20; k++)
            run_seq("random", int'($urandom_range(1, 40)), int'($urandom_range(3, 30)), 0, 0);

        // Reset in the middle of HOLD
        swi_reset_req = 1'b1;
        repeat (3) step();
        chk("mid rr before ack", cpu_resetrequest, 1);
        cpu_resettaken = 1'b1;
        step();
        cpu_resettaken = 1'b0;
        swi_reset_req  = 1'b0;
        repeat (5) step();
        chk("mid rr in hold", cpu_resetrequest, 1);
        #3 qsys_reset_n_sig = 1'b0;
        #1;
        chk("async rr", cpu_resetrequest, 0);
        chk("async busy", busy, 0);
        chk("async reset_count", reset_count, 0);
        chk("async timeout_flag", timeout_flag, 0);
        m_seq  = 0;
        m_flag = 1'b0;

        // Request already high when reset releases must not trigger
        swi_reset_req = 1'b1;
        repeat (2) step();
        qsys_reset_n_sig = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cpu_resetrequest || busy) seen++;
        end
        chk("held through reset no trigger", seen, 0);
        swi_reset_req = 1'b0;
        repeat (4) step();
        run_seq("post_reset", 5, 12, 0, 0);

        for (int k = 0; k < 256; k++)
            run_seq("wrap", int'($urandom_range(1, 6)), int'($urandom_range(3, 8)), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
